ca_rule_sequencer: RTL and testbench

//  Runs an elementary cellular automaton on a ring of WIDTH cells for a set number of generations.
//  A single 3-input rule LUT is shared: the block evaluates one cell per cycle and buffers the next row.
//  The row is committed when the last cell of a generation is evaluated.

---
 rtl/ca_rule_sequencer.sv | 136 +++++++++++++
 tb/tb_ca_rule_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer
//   Runs an elementary cellular automaton on a ring of WIDTH cells for a
//   programmable number of generations. One shared 3-input rule lookup
//   evaluates one cell per cycle into a next-row buffer. The buffered row is
//   committed to state_out when the last cell of a generation is evaluated.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      begin a run (accepted only in IDLE, ignored when abort is high)
//   abort      cancel any run, return to IDLE without a done pulse
//   seed       initial row, sampled on accepted start
//   num_gens   generation count, sampled on accepted start
//   busy       high while in RUN or DONE
//   done       one-cycle pulse on run completion
//   state_out  last committed row
//   gen_count  generations committed in the current/last run
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | evaluating one cell per cycle, committing a row every WIDTH cycles
// DONE   | done pulse cycle, returns to IDLE

module ca_rule_sequencer #(
  parameter int          WIDTH = 8,
  parameter logic [7:0]  RULE  = 8'h73,
  parameter int          GW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [GW-1:0]    num_gens,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] state_out,
  output logic [GW-1:0]    gen_count
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           fsm;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] next_row;
  logic [GW-1:0]    num_gens_q;

  logic [IW-1:0]    left_idx;
  logic [IW-1:0]    right_idx;
  logic [2:0]       lut_idx;
  logic             cell_val;
  logic [WIDTH-1:0] commit_row;
  logic [GW-1:0]    gen_inc;

  // Neighbourhood is always taken from the committed row, never from the
  // partially built next row, so every cell of a generation sees the same input.
  always_comb begin
    left_idx  = (idx == LAST) ? '0 : idx + IW'(1);
    right_idx = (idx == '0) ? LAST : idx - IW'(1);
    lut_idx   = {state_out[left_idx], state_out[idx], state_out[right_idx]};
    cell_val  = RULE[3'd7 - lut_idx];
    // The last cell goes straight into the committed row rather than via the buffer.
    commit_row = next_row;
    commit_row[WIDTH-1] = cell_val;
    gen_inc = gen_count + GW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      state_out  <= '0;
      gen_count  <= '0;
      idx        <= '0;
      next_row   <= '0;
      num_gens_q <= '0;
    end else if (abort) begin
      fsm  <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      idx  <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_out  <= seed;
            gen_count  <= '0;
            idx        <= '0;
            num_gens_q <= num_gens;
            busy       <= 1'b1;
            if (num_gens == '0) begin
              fsm  <= ST_DONE;
              done <= 1'b1;
            end else begin
              fsm <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          next_row[idx] <= cell_val;
          if (idx == LAST) begin
            state_out <= commit_row;
            gen_count <= gen_inc;
            idx       <= '0;
            if (gen_inc == num_gens_q) begin
              fsm  <= ST_DONE;
              done <= 1'b1;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          fsm  <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: begin
          fsm  <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_rule_sequencer.sv
module tb_ca_rule_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic [7:0] num_gens;
  logic       busy;
  logic       done;
  logic [7:0] state_out;
  logic [7:0] gen_count;

  int total = 0;
  int bad   = 0;

  ca_rule_sequencer #(.WIDTH(8), .RULE(8'h73), .GW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .num_gens  (num_gens),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .gen_count (gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock edge, then sit at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // caller is at a falling edge; returns at the falling edge of cycle k+1
  task automatic do_start(input logic [7:0] s, input logic [7:0] n);
    seed     = s;
    num_gens = n;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // cycles counted from k+1 (=1) until done is seen, bounded by max
  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < max) begin
      step();
      cyc++;
    end
  endtask

  // rule 0x73: output for {l,c,r}==i is rule[7-i]
  function automatic logic [7:0] ca_next(input logic [7:0] row);
    logic [7:0] rule_v;
    logic [7:0] nxt;
    logic [2:0] nb;
    rule_v = 8'h73;
    nxt = '0;
    for (int i = 0; i < 8; i++) begin
      nb = {row[(i + 1) % 8], row[i], row[(i + 7) % 8]};
      nxt[i] = rule_v[7 - int'(nb)];
    end
    return nxt;
  endfunction

  initial begin
    int         cyc;
    int         dcount;
    logic [7:0] mrow;
    logic [7:0] rs;
    logic [7:0] rn;

    reset = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_gens = '0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", state_out, 8'h00);
    chk("rst_gen", gen_count, 8'h00);
    reset = 1'b0;
    step();

    // T1: reset held 2 cycles in the middle of a run
    do_start(8'h01, 8'd4);
    chk("t1_busy_run", busy, 1'b1);
    step(); step(); step(); step(); step(); step(); step(); step(); step(); step();
    chk("t1_gen_pre", gen_count, 8'd1);
    reset = 1'b1;
    step(); step();
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done, 1'b0);
    chk("t1_state", state_out, 8'h00);
    chk("t1_gen", gen_count, 8'h00);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    chk("t1_no_done", dcount, 0);

    // T2: seed 0x01, one generation
    do_start(8'h01, 8'd1);
    chk("t2_busy", busy, 1'b1);
    step(); step(); step(); step();
    chk("t2_stable_mid", state_out, 8'h01);
    chk("t2_done_mid", done, 1'b0);
    step(); step(); step(); step();
    chk("t2_done_k9", done, 1'b1);
    chk("t2_state", state_out, 8'h03);
    chk("t2_gen", gen_count, 8'd1);
    step();
    chk("t2_done_off", done, 1'b0);
    chk("t2_busy_off", busy, 1'b0);

    // T3: seed 0x01, two generations
    do_start(8'h01, 8'd2);
    repeat (8) step();
    chk("t3_g1_state", state_out, 8'h03);
    chk("t3_g1_gen", gen_count, 8'd1);
    chk("t3_g1_done", done, 1'b0);
    chk("t3_g1_busy", busy, 1'b1);
    repeat (8) step();
    chk("t3_done_k17", done, 1'b1);
    chk("t3_g2_state", state_out, 8'h07);
    chk("t3_g2_gen", gen_count, 8'd2);
    step();
    chk("t3_busy_k18", busy, 1'b0);
    chk("t3_done_k18", done, 1'b0);

    // T4: boundary seeds and zero generations
    do_start(8'h00, 8'd3);
    wait_done(100, cyc);
    chk("t4_zero_cyc", cyc, 25);
    chk("t4_zero_state", state_out, 8'h00);
    chk("t4_zero_gen", gen_count, 8'd3);
    step();
    do_start(8'hFF, 8'd3);
    wait_done(100, cyc);
    chk("t4_ones_cyc", cyc, 25);
    chk("t4_ones_state", state_out, 8'hFF);
    chk("t4_ones_gen", gen_count, 8'd3);
    step();
    do_start(8'hA5, 8'd0);
    chk("t4_n0_done", done, 1'b1);
    chk("t4_n0_busy", busy, 1'b1);
    chk("t4_n0_state", state_out, 8'hA5);
    chk("t4_n0_gen", gen_count, 8'd0);
    step();
    chk("t4_n0_idle", busy, 1'b0);
    chk("t4_n0_done_off", done, 1'b0);

    // T5: ignored start while running, abort in gen2, start+abort in IDLE
    do_start(8'h01, 8'd4);
    step();
    seed = 8'hFF; num_gens = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("t5_g1_state", state_out, 8'h03);
    chk("t5_g1_busy", busy, 1'b1);
    chk("t5_g1_done", done, 1'b0);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_busy", busy, 1'b0);
    chk("t5_abort_done", done, 1'b0);
    chk("t5_abort_state", state_out, 8'h03);
    chk("t5_abort_gen", gen_count, 8'd1);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("t5_quiet", dcount, 0);
    chk("t5_state_held", state_out, 8'h03);
    seed = 8'h5A; num_gens = 8'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t5_sa_busy", busy, 1'b0);
    chk("t5_sa_state", state_out, 8'h03);
    step();
    chk("t5_sa_busy2", busy, 1'b0);

    // T6: random seeds against the software model
    for (int r = 0; r < 6; r++) begin
      rs = 8'($urandom);
      rn = 8'($urandom_range(1, 5));
      mrow = rs;
      do_start(rs, rn);
      chk("t6_seed", state_out, rs);
      for (int g = 1; g <= int'(rn); g++) begin
        repeat (8) step();
        mrow = ca_next(mrow);
        chk("t6_row", state_out, mrow);
        chk("t6_gen", gen_count, g);
        chk("t6_done", done, (g == int'(rn)) ? 1'b1 : 1'b0);
      end
      step();
      chk("t6_idle", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
